freq_gate_ctrl: RTL and testbench

//  Measurement sequencer for the frequency meter. Derives the 1 us timebase

---
 rtl/freq_gate_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_freq_gate_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_gate_ctrl.sv
// ---------------------------------------------------------------------------
// freq_gate_ctrl
//   Measurement sequencer for the frequency meter. Derives a 1 us timebase
//   strobe from clk, then repeatedly clears the BCD edge counter, opens the
//   count gate for a whole number of timebase ticks, and latches the result.
//   Optional auto-ranging steers the gate length from overflow / top-digit
//   feedback. Results are offered to the display with a valid/ack handshake.
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   n10_50          clock select: 1 = 50 MHz (DIV_50), 0 = 10 MHz (DIV_10)
//   gate_sel[1:0]   manual gate range, used when auto_range = 0
//   auto_range      1 = range chosen from carry_in / msd_zero feedback
//   single          1 = one measurement per start pulse, 0 = free-running
//   start           measurement trigger, honoured only in IDLE
//   carry_in        BCD counter overflow pulse (counted during the gate only)
//   msd_zero        BCD counter top digit is zero (level)
//   result_ack      display has consumed the latched result
//   tick_1us        1-cycle timebase strobe
//   gate_en         edge-count enable to the BCD counter
//   ctr_clr         1-cycle clear to the BCD counter
//   latch           1-cycle latch strobe to the BCD counter
//   range[1:0]      range of the latched result
//   overrange       overflow seen during the latched gate
//   result_valid    latched result not yet acknowledged
//   overrun         sticky: a result was latched over an unacknowledged one
//   busy            sequencer is not idle
// ---------------------------------------------------------------------------
module freq_gate_ctrl #(
    parameter int unsigned DIV_50  = 50,
    parameter int unsigned DIV_10  = 10,
    parameter int unsigned G0      = 10_000,
    parameter int unsigned G1      = 100_000,
    parameter int unsigned G2      = 1_000_000,
    parameter int unsigned G3      = 10_000_000,
    parameter int unsigned DEAD_US = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       n10_50,
    input  logic [1:0] gate_sel,
    input  logic       auto_range,
    input  logic       single,
    input  logic       start,
    input  logic       carry_in,
    input  logic       msd_zero,
    input  logic       result_ack,
    output logic       tick_1us,
    output logic       gate_en,
    output logic       ctr_clr,
    output logic       latch,
    output logic [1:0] range,
    output logic       overrange,
    output logic       result_valid,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned DIV_MAX = (DIV_50 > DIV_10) ? DIV_50 : DIV_10;
    localparam int unsigned PW      = $clog2(DIV_MAX + 1);
    localparam int unsigned G01     = (G0 > G1) ? G0 : G1;
    localparam int unsigned G23     = (G2 > G3) ? G2 : G3;
    localparam int unsigned GMAX    = (G01 > G23) ? G01 : G23;
    localparam int unsigned CMAX    = (GMAX > DEAD_US) ? GMAX : DEAD_US;
    localparam int unsigned TW      = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ARM,
        S_GATE,
        S_LATCH,
        S_DEAD
    } state_t;

    state_t          r_state;
    logic [PW-1:0]   r_presc;
    logic [1:0]      r_cur;
    logic            r_auto;
    logic            r_ov;
    logic [TW-1:0]   r_tcnt;

    logic [PW-1:0]   w_div_m1;
    logic [PW-1:0]   w_presc_nxt;
    logic [TW-1:0]   w_glen_m1;

    // ----------------------------------------------------------------------
    // Timebase prescaler. The >= compare lets a switch to the shorter
    // divider wrap immediately instead of running past the new terminal.
    // The strobe is registered from the next count so it is high exactly
    // while the count sits at DIV-1.
    // ----------------------------------------------------------------------
    always_comb begin
        w_div_m1    = n10_50 ? PW'(DIV_50 - 1) : PW'(DIV_10 - 1);
        w_presc_nxt = (r_presc >= w_div_m1) ? '0 : r_presc + PW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc  <= '0;
            tick_1us <= 1'b0;
        end else begin
            r_presc  <= w_presc_nxt;
            tick_1us <= (w_presc_nxt == w_div_m1);
        end
    end

    always_comb begin
        w_glen_m1 = TW'(G0 - 1);
        case (r_cur)
            2'd0: w_glen_m1 = TW'(G0 - 1);
            2'd1: w_glen_m1 = TW'(G1 - 1);
            2'd2: w_glen_m1 = TW'(G2 - 1);
            2'd3: w_glen_m1 = TW'(G3 - 1);
            default: w_glen_m1 = TW'(G0 - 1);
        endcase
    end

    // ----------------------------------------------------------------------
    // Sequencer. Strobe/level outputs are set on the edge that enters the
    // corresponding state, so they are high exactly while in that state.
    // Result fields are written by the LATCH state and appear one cycle
    // after the latch strobe; an ack in the latch cycle therefore loses to
    // the new result.
    // ----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cur        <= 2'd2;
            r_auto       <= 1'b0;
            r_ov         <= 1'b0;
            r_tcnt       <= '0;
            gate_en      <= 1'b0;
            ctr_clr      <= 1'b0;
            latch        <= 1'b0;
            range        <= 2'd0;
            overrange    <= 1'b0;
            result_valid <= 1'b0;
            overrun      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            ctr_clr <= 1'b0;
            latch   <= 1'b0;

            if (result_ack) begin
                result_valid <= 1'b0;
                overrun      <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (!single || start) begin
                        r_state <= S_CLEAR;
                        ctr_clr <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    r_state <= S_ARM;
                    if (!auto_range) begin
                        r_cur <= gate_sel;
                    end
                    r_auto <= auto_range;
                    r_tcnt <= '0;
                    r_ov   <= 1'b0;
                end
                S_ARM: begin
                    if (tick_1us) begin
                        r_state <= S_GATE;
                        gate_en <= 1'b1;
                    end
                end
                S_GATE: begin
                    r_ov <= r_ov | carry_in;
                    if (tick_1us) begin
                        if (r_tcnt == w_glen_m1) begin
                            r_state <= S_LATCH;
                            gate_en <= 1'b0;
                            latch   <= 1'b1;
                        end else begin
                            r_tcnt <= r_tcnt + TW'(1);
                        end
                    end
                end
                S_LATCH: begin
                    r_state      <= S_DEAD;
                    r_tcnt       <= '0;
                    range        <= r_cur;
                    overrange    <= r_ov;
                    result_valid <= 1'b1;
                    // An ack arriving with the latch consumes the old result,
                    // so it is not counted as overrun.
                    if (result_valid && !result_ack) begin
                        overrun <= 1'b1;
                    end
                    if (r_auto) begin
                        if (r_ov && (r_cur != 2'd0)) begin
                            r_cur <= r_cur - 2'd1;
                        end else if (msd_zero && (r_cur != 2'd3)) begin
                            r_cur <= r_cur + 2'd1;
                        end
                    end
                end
                S_DEAD: begin
                    if (tick_1us) begin
                        if (r_tcnt == TW'(DEAD_US - 1)) begin
                            r_state <= S_IDLE;
                            busy    <= 1'b0;
                        end else begin
                            r_tcnt <= r_tcnt + TW'(1);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    gate_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freq_gate_ctrl.sv
module tb_freq_gate_ctrl;

    localparam int unsigned P_DIV_50  = 5;
    localparam int unsigned P_DIV_10  = 2;
    localparam int unsigned P_DEAD_US = 2;
    localparam int          GLEN [4]  = '{4, 8, 16, 32};

    localparam int S_TICK  = 0;
    localparam int S_GATE  = 1;
    localparam int S_CLR   = 2;
    localparam int S_LATCH = 3;
    localparam int S_BUSY  = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       n10_50;
    logic [1:0] gate_sel;
    logic       auto_range;
    logic       single;
    logic       start;
    logic       carry_in;
    logic       msd_zero;
    logic       result_ack;
    logic       tick_1us;
    logic       gate_en;
    logic       ctr_clr;
    logic       latch;
    logic [1:0] range;
    logic       overrange;
    logic       result_valid;
    logic       overrun;
    logic       busy;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    freq_gate_ctrl #(
        .DIV_50  (P_DIV_50),
        .DIV_10  (P_DIV_10),
        .G0      (4),
        .G1      (8),
        .G2      (16),
        .G3      (32),
        .DEAD_US (P_DEAD_US)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .n10_50       (n10_50),
        .gate_sel     (gate_sel),
        .auto_range   (auto_range),
        .single       (single),
        .start        (start),
        .carry_in     (carry_in),
        .msd_zero     (msd_zero),
        .result_ack   (result_ack),
        .tick_1us     (tick_1us),
        .gate_en      (gate_en),
        .ctr_clr      (ctr_clr),
        .latch        (latch),
        .range        (range),
        .overrange    (overrange),
        .result_valid (result_valid),
        .overrun      (overrun),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Reference model: measurement phases with the gate as a cycle budget
    // (gate length * divider) and the dead time as a tick count.
    // ------------------------------------------------------------------
    typedef enum {PH_IDLE, PH_CLR, PH_ARM, PH_GATE, PH_LAT, PH_DEAD} phase_t;

    phase_t m_ph    = PH_IDLE;
    int     m_cnt   = 0;
    int     m_div   = 0;
    bit     m_tk    = 1'b0;
    int     m_left  = 0;
    int     m_dt    = 0;
    int     m_cur   = 2;
    bit     m_auto  = 1'b0;
    bit     m_ov    = 1'b0;
    bit     e_tick  = 1'b0;
    int     e_range = 0;
    bit     e_over  = 1'b0;
    bit     e_valid = 1'b0;
    bit     e_orun  = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_ph = PH_IDLE; m_cnt = 0; e_tick = 0; m_cur = 2; m_auto = 0;
            m_ov = 0; e_range = 0; e_over = 0; e_valid = 0; e_orun = 0;
        end else begin
            m_div  = n10_50 ? P_DIV_50 : P_DIV_10;
            m_tk   = e_tick;
            m_cnt  = (m_cnt >= m_div - 1) ? 0 : m_cnt + 1;
            e_tick = (m_cnt == m_div - 1);
            if (result_ack) begin
                e_valid = 0;
                e_orun  = 0;
            end
            case (m_ph)
                PH_IDLE: if (!single || start) m_ph = PH_CLR;
                PH_CLR: begin
                    if (!auto_range) m_cur = int'(gate_sel);
                    m_auto = auto_range;
                    m_ov   = 0;
                    m_ph   = PH_ARM;
                end
                PH_ARM: if (m_tk) begin
                    m_ph   = PH_GATE;
                    m_left = GLEN[m_cur] * m_div;
                end
                PH_GATE: begin
                    m_ov   = m_ov | carry_in;
                    m_left = m_left - 1;
                    if (m_left == 0) m_ph = PH_LAT;
                end
                PH_LAT: begin
                    e_range = m_cur;
                    e_over  = m_ov;
                    if (e_valid) e_orun = 1;
                    e_valid = 1;
                    if (m_auto) begin
                        if (m_ov && m_cur > 0) m_cur = m_cur - 1;
                        else if (msd_zero && m_cur < 3) m_cur = m_cur + 1;
                    end
                    m_dt = 0;
                    m_ph = PH_DEAD;
                end
                default: if (m_tk) begin
                    m_dt = m_dt + 1;
                    if (m_dt == P_DEAD_US) m_ph = PH_IDLE;
                end
            endcase
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("tick_1us",     32'(tick_1us),     32'(e_tick));
            chk("gate_en",      32'(gate_en),      32'(m_ph == PH_GATE));
            chk("ctr_clr",      32'(ctr_clr),      32'(m_ph == PH_CLR));
            chk("latch",        32'(latch),        32'(m_ph == PH_LAT));
            chk("busy",         32'(busy),         32'(m_ph != PH_IDLE));
            chk("range",        32'(range),        32'(e_range));
            chk("overrange",    32'(overrange),    32'(e_over));
            chk("result_valid", 32'(result_valid), 32'(e_valid));
            chk("overrun",      32'(overrun),      32'(e_orun));
        end
    end

    function automatic logic sig(input int s);
        case (s)
            S_TICK:  return tick_1us;
            S_GATE:  return gate_en;
            S_CLR:   return ctr_clr;
            S_LATCH: return latch;
            S_BUSY:  return busy;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_sig(input int s, input logic v, input int budget, input string nm);
        int n;
        n = 0;
        while (sig(s) !== v && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sig(s) !== v) begin
            n_chk++;
            n_err++;
            $display("FAIL %s: timed out after %0d cycles, level %0b required", nm, budget, v);
        end
    endtask

    task automatic gate_len(input string nm, input int exp);
        int n;
        n = 0;
        wait_sig(S_GATE, 1'b1, 400, {nm, "_rise"});
        while (gate_en === 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 32'(n), 32'(exp));
    endtask

    task automatic tick_period(input string nm, input int exp);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tick_1us !== 1'b1 && n < 20);
        chk(nm, 32'(n), 32'(exp));
    endtask

    task automatic rnd_run(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            rst        = ($urandom_range(0, 799) == 0);
            start      = ($urandom_range(0, 15) == 0);
            carry_in   = ($urandom_range(0, 39) == 0);
            result_ack = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 9) == 0)   msd_zero   = ~msd_zero;
            if ($urandom_range(0, 199) == 0) single     = ~single;
            if ($urandom_range(0, 49) == 0)  gate_sel   = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 149) == 0) auto_range = ~auto_range;
        end
    endtask

    initial begin
        int     n;
        int     lat;
        bit     did;
        int     exp_rng [4];

        rst = 1; n10_50 = 1; gate_sel = 0; auto_range = 0; single = 1;
        start = 0; carry_in = 0; msd_zero = 0; result_ack = 0;
        @(negedge clk);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_gate_en", 32'(gate_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_range", 32'(range), 32'd0);
        rst = 0;

        // Prescaler 5 then 2; single with no start keeps the sequencer idle.
        wait_sig(S_TICK, 1'b1, 20, "first_tick");
        tick_period("tick_period_50", 5);
        tick_period("tick_period_50b", 5);
        n10_50 = 0;
        tick_period("tick_period_10", 2);
        tick_period("tick_period_10b", 2);
        n10_50 = 1;
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy === 1'b1) n++;
        end
        chk("idle_no_start_busy", 32'(n), 32'd0);

        // Free-run, manual range 1.
        single = 0; gate_sel = 1;
        wait_sig(S_CLR, 1'b1, 10, "ctr_clr");
        gate_len("gate_len_g1", 40);
        chk("latch_after_gate", 32'(latch), 32'd1);
        @(negedge clk);
        chk("range_g1", 32'(range), 32'd1);
        chk("valid_set", 32'(result_valid), 32'd1);
        chk("overrun_clear", 32'(overrun), 32'd0);

        // Handshake.
        wait_sig(S_LATCH, 1'b1, 200, "latch2");
        @(negedge clk);
        chk("overrun_set", 32'(overrun), 32'd1);
        wait_sig(S_LATCH, 1'b1, 200, "latch3");
        result_ack = 1;
        @(negedge clk);
        result_ack = 0;
        chk("ack_with_latch_valid", 32'(result_valid), 32'd1);
        chk("ack_with_latch_overrun", 32'(overrun), 32'd0);
        result_ack = 1;
        @(negedge clk);
        result_ack = 0;
        chk("ack_clears_valid", 32'(result_valid), 32'd0);
        chk("ack_clears_overrun", 32'(overrun), 32'd0);

        // Single-shot: one measurement per start; start during the gate ignored.
        single = 1;
        wait_sig(S_BUSY, 1'b0, 200, "back_to_idle");
        start = 1;
        @(negedge clk);
        start = 0;
        lat = 0; did = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            start = gate_en && !did;
            if (start) did = 1;
            if (latch === 1'b1) lat++;
        end
        chk("single_latch_count", 32'(lat), 32'd1);
        chk("single_idle_after", 32'(busy), 32'd0);

        // Auto-range from reset.
        rst = 1; auto_range = 1; single = 0; gate_sel = 0;
        @(negedge clk);
        rst = 0;
        wait_sig(S_GATE, 1'b1, 30, "auto_gate");
        repeat (5) @(negedge clk);
        carry_in = 1;
        @(negedge clk);
        carry_in = 0;
        wait_sig(S_LATCH, 1'b1, 300, "auto_latch1");
        @(negedge clk);
        chk("auto_overrange", 32'(overrange), 32'd1);
        chk("auto_range_first", 32'(range), 32'd2);
        result_ack = 1;
        @(negedge clk);
        result_ack = 0;
        wait_sig(S_LATCH, 1'b1, 300, "auto_latch2");
        @(negedge clk);
        chk("auto_range_down", 32'(range), 32'd1);
        chk("auto_overrange_clr", 32'(overrange), 32'd0);
        msd_zero = 1;
        exp_rng = '{1, 2, 3, 3};
        for (int k = 0; k < 4; k++) begin
            wait_sig(S_LATCH, 1'b1, 400, "auto_latch_up");
            @(negedge clk);
            chk($sformatf("auto_range_up%0d", k), 32'(range), 32'(exp_rng[k]));
        end
        msd_zero = 0;

        // Reset in the middle of a gate.
        wait_sig(S_GATE, 1'b1, 400, "rst_gate");
        repeat (7) @(negedge clk);
        rst = 1;
        @(negedge clk);
        chk("midrst_gate_en", 32'(gate_en), 32'd0);
        chk("midrst_latch", 32'(latch), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_valid", 32'(result_valid), 32'd0);
        chk("midrst_range", 32'(range), 32'd0);
        rst = 0;
        gate_len("gate_len_restart_g2", 80);
        chk("restart_latch", 32'(latch), 32'd1);
        @(negedge clk);
        chk("restart_range", 32'(range), 32'd2);

        // Randomised traffic at both clock rates.
        rnd_run(4000);
        @(negedge clk);
        rst = 1; n10_50 = 0;
        @(negedge clk);
        rst = 0;
        rnd_run(4000);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
